// File: rtl/booth_mult8_stream.sv
// ---------------------------------------------------------------------------
// booth_mult8_stream
//
// Stream front end for booth_mult8_core. Operand requests arrive on a
// valid/ready stream and are queued in a small FIFO. A four-state FSM pops
// one request at a time, loads it into the core operand registers, pulses
// core_start and waits for core_done. The product is captured into an output
// register and offered on a valid/ready stream. If the consumer is stalled
// when the core finishes, the FSM parks in HOLD. The core keeps its product
// stable until the next start, so no result is lost while parked.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_ready is the inverted
//                       registered full flag
//   in_a, in_b          multiplicand / multiplier
//   in_sign_mode        [1] A signed, [0] B signed
//   core_start          one-cycle start pulse to the core
//   core_multiplicand   registered operand A
//   core_multiplier     registered operand B
//   core_sign_mode      registered sign mode
//   core_product        core result, stable from done until the next start
//   core_done           one-cycle completion pulse from the core
//   out_valid/out_ready result handshake
//   out_product         result register
//   busy                FIFO non-empty, FSM not idle, or result pending
//   err_timeout         sticky, core did not answer within TIMEOUT cycles
//   err_spurious        sticky, core_done seen outside WAIT
// ---------------------------------------------------------------------------
module booth_mult8_stream #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_sign_mode,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_multiplicand,
  output logic [WIDTH-1:0]     core_multiplier,
  output logic [1:0]           core_sign_mode,
  input  logic [2*WIDTH-1:0]   core_product,
  input  logic                 core_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_spurious
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Request FIFO
  // -------------------------------------------------------------------------
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;

  logic             w_wr;
  logic             w_pop;
  logic             w_empty;
  logic [CNT_W-1:0] w_count_nxt;
  logic [ENT_W-1:0] w_head;

  state_t           r_state;
  state_t           w_state_nxt;

  // Gating the write on the registered full flag alone means a pop can never
  // make room for a write in the same cycle, so in_ready has no
  // combinational dependence on in_valid or on the FSM.
  assign in_ready = ~r_full;
  assign w_wr     = in_valid & ~r_full;
  assign w_empty  = (r_count == '0);
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;
  assign w_head   = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset: an entry is never read before it is written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {in_sign_mode, in_b, in_a};
    end
  end

  // FIFO_DEPTH is a power of two, so pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
    end
  end

  // -------------------------------------------------------------------------
  // Sequencing FSM
  // -------------------------------------------------------------------------
  logic [TMO_W-1:0] r_wait_cnt;
  logic             r_out_valid;
  logic             w_out_free;
  logic             w_capture;
  logic             w_timeout;
  logic             w_spurious;

  // The output register can take a new product when it is empty or when its
  // current product is handed over in this same cycle.
  assign w_out_free = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_spurious  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_spurious = core_done;
        if (!w_empty) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_spurious  = core_done;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (w_out_free) begin
            w_capture   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else if (r_wait_cnt == TMO_W'(TIMEOUT - 1)) begin
          // TIMEOUT full WAIT cycles without done: drop the request.
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        w_spurious = core_done;
        if (w_out_free) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + TMO_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Core operand registers
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [1:0]       r_op_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_mode <= '0;
    end else if (w_pop) begin
      {r_op_mode, r_op_b, r_op_a} <= w_head;
    end
  end

  assign core_start        = (r_state == S_ISSUE);
  assign core_multiplicand = r_op_a;
  assign core_multiplier   = r_op_b;
  assign core_sign_mode    = r_op_mode;

  // -------------------------------------------------------------------------
  // Result register and output handshake
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] r_out_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else begin
      // A capture in the same cycle as a handshake keeps out_valid high.
      r_out_valid <= w_capture | (r_out_valid & ~out_ready);
      if (w_capture) begin
        r_out_product <= core_product;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;

  // -------------------------------------------------------------------------
  // Status and sticky error flags
  // -------------------------------------------------------------------------
  logic r_err_timeout;
  logic r_err_spurious;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if (w_spurious) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

  assign err_timeout  = r_err_timeout;
  assign err_spurious = r_err_spurious;
  assign busy         = ~w_empty | (r_state != S_IDLE) | r_out_valid;

endmodule

// File: tb/tb_booth_mult8_stream.sv
// ---------------------------------------------------------------------------
// tb_booth_mult8_stream
//
// Directed bench for booth_mult8_stream. A behavioural stand-in for
// booth_mult8_core answers every start with done four cycles after the start
// is sampled. That gives the 6-cycle input-to-output latency of the real core.
// The stand-in can also be told never to answer, and the bench can inject a
// stray done pulse.
// ---------------------------------------------------------------------------
module tb_booth_mult8_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_sign_mode;
  logic        core_start;
  logic [7:0]  core_multiplicand;
  logic [7:0]  core_multiplier;
  logic [1:0]  core_sign_mode;
  logic [15:0] core_product;
  logic        core_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        busy;
  logic        err_timeout;
  logic        err_spurious;

  always #5 clk = ~clk;

  booth_mult8_stream #(
    .WIDTH      (8),
    .FIFO_DEPTH (2),
    .TIMEOUT    (15)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_a              (in_a),
    .in_b              (in_b),
    .in_sign_mode      (in_sign_mode),
    .core_start        (core_start),
    .core_multiplicand (core_multiplicand),
    .core_multiplier   (core_multiplier),
    .core_sign_mode    (core_sign_mode),
    .core_product      (core_product),
    .core_done         (core_done),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_product       (out_product),
    .busy              (busy),
    .err_timeout       (err_timeout),
    .err_spurious      (err_spurious)
  );

  // Core stand-in
  logic       stub_nodone;
  logic       done_inj;
  logic [3:0] stub_cnt;

  function automatic logic [15:0] core_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] m);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = m[1] ? {{8{a[7]}}, a} : {8'h00, a};
    eb = m[0] ? {{8{b[7]}}, b} : {8'h00, b};
    core_model = ea * eb;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt     <= 4'd0;
      core_product <= 16'h0000;
    end else if (core_start) begin
      core_product <= core_model(core_multiplicand, core_multiplier, core_sign_mode);
      stub_cnt     <= stub_nodone ? 4'd0 : 4'd4;
    end else if (stub_cnt != 4'd0) begin
      stub_cnt <= stub_cnt - 4'd1;
    end
  end

  assign core_done = (stub_cnt == 4'd1) | done_inj;

  // Recorders: accepted products and start-pulse cycle numbers
  logic [15:0] got[$];
  int          start_t[$];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (out_valid && out_ready) got.push_back(out_product);
    if (core_start) start_t.push_back(cyc);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    int t;
    t = 0;
    in_a         = a;
    in_b         = b;
    in_sign_mode = m;
    in_valid     = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int base, input int n);
    int t;
    t = 0;
    while (got.size() < base + n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("outs_arrived", got.size() - base, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          sb;
    int          min_gap;
    logic        ov_seen;
    logic [15:0] burst_exp [8];

    burst_exp = '{16'h0002, 16'h0006, 16'h000C, 16'h0014,
                  16'h001E, 16'h002A, 16'h0038, 16'h0048};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = 8'h00;
    in_b         = 8'h00;
    in_sign_mode = 2'b00;
    out_ready    = 1'b1;
    stub_nodone  = 1'b0;
    done_inj     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_in_ready",  {31'd0, in_ready},     32'd1);
    check("rst_out_valid", {31'd0, out_valid},    32'd0);
    check("rst_product",   {16'd0, out_product},  32'd0);
    check("rst_busy",      {31'd0, busy},         32'd0);
    check("rst_start",     {31'd0, core_start},   32'd0);
    check("rst_err_to",    {31'd0, err_timeout},  32'd0);
    check("rst_err_sp",    {31'd0, err_spurious}, 32'd0);

    // Signed x signed, latency and single start pulse
    sb = start_t.size();
    send(8'hFD, 8'h05, 2'b11);
    repeat (5) @(negedge clk);
    check("t1_not_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_product",   {16'd0, out_product}, 32'h0000FFF1);
    check("t1_starts",    start_t.size() - sb, 32'd1);
    @(negedge clk);

    // Unsigned and mixed, in order
    base = got.size();
    send(8'hFF, 8'hFF, 2'b00);
    send(8'hFF, 8'hFF, 2'b10);
    wait_outs(base, 2);
    check("t2_uu", {16'd0, got[base]},     32'h0000FE01);
    check("t2_su", {16'd0, got[base + 1]}, 32'h0000FF01);

    // Back-pressure: second result parks, FIFO fills
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    base = got.size();
    send(8'h02, 8'h03, 2'b00);
    send(8'h80, 8'h02, 2'b11);
    send(8'h10, 8'h10, 2'b00);
    send(8'h7F, 8'h81, 2'b01);
    repeat (10) @(negedge clk);
    check("bp_in_ready",  {31'd0, in_ready},  32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_prod", {16'd0, out_product}, 32'h00000006);
    check("bp_none_out",  got.size() - base, 32'd0);
    check("bp_busy",      {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    wait_outs(base, 4);
    check("bp_r0", {16'd0, got[base]},     32'h00000006);
    check("bp_r1", {16'd0, got[base + 1]}, 32'h0000FF00);
    check("bp_r2", {16'd0, got[base + 2]}, 32'h00000100);
    check("bp_r3", {16'd0, got[base + 3]}, 32'h0000C0FF);
    repeat (10) @(negedge clk);
    check("bp_no_dup", got.size() - base, 32'd4);

    // Burst of 8 with out_ready held high
    base = got.size();
    sb   = start_t.size();
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), 8'(i + 2), 2'b00);
    end
    wait_outs(base, 8);
    check("burst_busy_low", {31'd0, busy}, 32'd0);
    check("burst_starts", start_t.size() - sb, 32'd8);
    min_gap = 1000;
    for (int i = sb + 1; i < start_t.size(); i++) begin
      if (start_t[i] - start_t[i - 1] < min_gap) min_gap = start_t[i] - start_t[i - 1];
    end
    check("burst_gap_ge6", {31'd0, (min_gap >= 6)}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("burst_r%0d", i), {16'd0, got[base + i]}, {16'd0, burst_exp[i]});
    end

    // Core never answers: timeout after 15 WAIT cycles, then recovery
    repeat (3) @(negedge clk);
    check("to_clear_before", {31'd0, err_timeout}, 32'd0);
    stub_nodone = 1'b1;
    send(8'h01, 8'h01, 2'b00);
    repeat (16) @(negedge clk);
    check("to_not_early", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    check("to_set",       {31'd0, err_timeout}, 32'd1);
    check("to_no_output", {31'd0, out_valid},   32'd0);
    check("to_idle",      {31'd0, busy},        32'd0);
    stub_nodone = 1'b0;
    base = got.size();
    send(8'h03, 8'h04, 2'b00);
    wait_outs(base, 1);
    check("to_recover", {16'd0, got[base]}, 32'h0000000C);
    check("to_sticky",  {31'd0, err_timeout}, 32'd1);

    // Stray done while idle
    repeat (3) @(negedge clk);
    check("sp_clear_before", {31'd0, err_spurious}, 32'd0);
    done_inj = 1'b1;
    @(negedge clk);
    done_inj = 1'b0;
    check("sp_set", {31'd0, err_spurious}, 32'd1);
    repeat (2) @(negedge clk);
    check("sp_no_output", {31'd0, out_valid}, 32'd0);

    // Reset while waiting on the core with two requests queued
    repeat (3) @(negedge clk);
    send(8'h05, 8'h06, 2'b00);
    send(8'h07, 8'h08, 2'b00);
    send(8'h09, 8'h0A, 2'b00);
    check("rw_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rw_start",   {31'd0, core_start},        32'd0);
    check("rw_opa",     {24'd0, core_multiplicand}, 32'd0);
    check("rw_opb",     {24'd0, core_multiplier},   32'd0);
    check("rw_mode",    {30'd0, core_sign_mode},    32'd0);
    check("rw_ovalid",  {31'd0, out_valid},         32'd0);
    check("rw_prod",    {16'd0, out_product},       32'd0);
    check("rw_busy",    {31'd0, busy},              32'd0);
    check("rw_err_to",  {31'd0, err_timeout},       32'd0);
    check("rw_err_sp",  {31'd0, err_spurious},      32'd0);
    rst_n = 1'b1;
    sb = start_t.size();
    ov_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      ov_seen = ov_seen | out_valid;
    end
    check("rw_no_ovalid",  {31'd0, ov_seen},   32'd0);
    check("rw_no_start",   start_t.size() - sb, 32'd0);
    check("rw_in_ready",   {31'd0, in_ready},  32'd1);
    check("rw_busy_after", {31'd0, busy},      32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_mult8_stream.md
Name: booth_mult8_stream

Overview:
- Stream adapter on the input side of booth_mult8_core; also owns capture of that core's result.
- Accepts operand requests on a valid/ready stream and buffers them in a small FIFO.
- Issues one start pulse per request to the core and waits for its done.
- Captures core_product into an output register and presents it on a valid/ready stream, so a stalled consumer never loses a product.

Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits.
- FIFO_DEPTH, 2, request FIFO entries; power of two, >= 2.
- TIMEOUT, 15, maximum cycles in WAIT before the timeout error is flagged.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  FIFO not full
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier
- in_sign_mode  in  2  [1] A signed, [0] B signed
- core_start  out  1  one-cycle start pulse to the core
- core_multiplicand  out  WIDTH  registered operand A
- core_multiplier  out  WIDTH  registered operand B
- core_sign_mode  out  2  registered sign mode
- core_product  in  2*WIDTH  core result; stable from done until the next start
- core_done  in  1  one-cycle completion pulse from the core
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_product  out  2*WIDTH  result register
- busy  out  1  FIFO non-empty, or FSM not in IDLE, or out_valid
- err_timeout  out  1  sticky; set on a WAIT timeout
- err_spurious  out  1  sticky; set on core_done outside WAIT

Behaviour:
- Reset values: all outputs, FIFO pointers and counters are 0; in_ready is 1 once reset is released; FSM is in IDLE.
- Reset mid-operation discards FIFO contents and the in-flight request.
- FIFO:
  - Write on in_valid & in_ready; pop only by the FSM in IDLE.
  - A simultaneous write and pop when full is not permitted: in_ready depends only on the registered full flag.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is 0..FIFO_DEPTH.
- FSM, state IDLE:
  - If the FIFO is non-empty: pop the head into the core_* operand registers and go to ISSUE.
  - No issue while in HOLD.
- FSM, state ISSUE:
  - core_start = 1 for exactly this cycle; go to WAIT.
  - Clear the wait counter.
- FSM, state WAIT:
  - Wait counter increments each cycle.
  - On core_done, out register free: capture core_product into out_product, set out_valid, go to IDLE.
  - On core_done, out register occupied and not draining this cycle: go to HOLD.
  - "Free" means out_valid = 0, or out_valid & out_ready in the same cycle; the capture then overwrites and out_valid stays 1.
  - If the counter reaches TIMEOUT with no done: set err_timeout, go to IDLE, drop the request, capture nothing.
- FSM, state HOLD:
  - Wait until the out register is free, then capture core_product, set out_valid, go to IDLE.
  - Valid because the core holds its product until the next start.
- Output handshake:
  - out_valid & out_ready clears out_valid unless a capture occurs in the same cycle.
  - out_product holds its value while out_valid = 1 and out_ready = 0.
- core_done in IDLE, ISSUE or HOLD sets err_spurious and is otherwise ignored.
- Ordering: results leave in the same order requests were accepted.
- Latency: accept at edge E0 → pop at E1 → core_start high between E1 and E2 → out_valid at the edge after the core_done cycle.
  - With booth_mult8_core, input-to-output is 6 cycles.
  - Throughput is one request per 6 cycles while out_ready = 1.
- No combinational path from in_valid to in_ready, from out_ready to out_valid, or from core_done to core_start.

Test Plan:
- Signed × signed: in_a = 0xFD, in_b = 0x05, sign_mode 11 → one core_start pulse; out_product = 0xFFF1; out_valid at E0+6.
- Unsigned and mixed: 0xFF × 0xFF with mode 00 → 0xFE01; 0xFF × 0xFF with mode 10 → 0xFF01; results emerge in request order.
- Back-pressure: hold out_ready = 0, send 4 requests.
  - Second result parks in HOLD; FIFO fills and in_ready = 0.
  - Release out_ready → all 4 products delivered in order, none lost or duplicated.
- Burst with out_ready = 1: 8 back-to-back requests → exactly 8 core_start pulses, each at least 6 cycles apart; busy falls 1 cycle after the last output handshake.
- Fault stub in place of the core:
  - Never asserts done → err_timeout set after 15 WAIT cycles; FSM returns to IDLE; the next request completes normally.
  - Done pulsed in IDLE → err_spurious set; out_valid stays 0.
- Reset mid-WAIT with 2 requests queued → all outputs 0 and FIFO empty on the following cycle; no out_valid afterwards without new requests.
